// File: rtl/sr_ff_driver.sv
// Queued SET/RESET/TOGGLE sequencer that drives an SR flip-flop and checks its q/qn readback.
// Optional macro SR_FF_DRIVER_TOGGLE_EN enables TOGGLE; without it op 11 pops as an error NOP.
module sr_ff_driver #(
  parameter int DEPTH     = 4,
  parameter int PULSE_W   = 1,
  parameter int CHECK_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic       err_clr,
  output logic       s,
  output logic       r,
  input  logic       q,
  input  logic       qn,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_W - 1);
  localparam logic [3:0] CHECK_LOAD = 4'(CHECK_LAT - 1);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10
  } state_t;

  logic [1:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  state_t      state_r;
  logic        exp_r;
  logic [3:0]  cnt_r;

  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic [1:0]  head_s;

  // FIFO status; push depends only on !full, never on a same-cycle pop.
  always_comb begin
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    empty_s = (wr_ptr_r == rd_ptr_r);
    push_s  = req_valid && !full_s;
    head_s  = mem_r[rd_ptr_r[AW-1:0]];
  end

  assign req_ready = !full_s;
  assign busy      = (state_r != IDLE) || !empty_s;

  // Command storage; contents are don't-care once the pointers are flushed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= req_op;
    end
  end

  // Write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
    end else if (push_s) begin
      wr_ptr_r <= wr_ptr_r + PTR_ONE;
    end
  end

  // Sequencer: pop, drive a one-hot s/r pulse, wait, then check readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rd_ptr_r <= PTR_ZERO;
      exp_r    <= 1'b0;
      cnt_r    <= 4'd0;
      s        <= 1'b0;
      r        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Later assignments to err in this block override the clear.
      if (err_clr) begin
        err <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case (head_s)
              OP_SET: begin
                exp_r   <= 1'b1;
                s       <= 1'b1;
                r       <= 1'b0;
                cnt_r   <= PULSE_LOAD;
                state_r <= DRIVE;
              end
              OP_RESET: begin
                exp_r   <= 1'b0;
                s       <= 1'b0;
                r       <= 1'b1;
                cnt_r   <= PULSE_LOAD;
                state_r <= DRIVE;
              end
              OP_TOGGLE: begin
`ifdef SR_FF_DRIVER_TOGGLE_EN
                exp_r   <= !q;
                s       <= !q;
                r       <= q;
                cnt_r   <= PULSE_LOAD;
                state_r <= DRIVE;
`else
                err  <= 1'b1;
                done <= 1'b1;
`endif
              end
              OP_NOP: begin
                done <= 1'b1;
              end
              default: begin
                done <= 1'b1;
              end
            endcase
          end
        end
        DRIVE: begin
          if (cnt_r == 4'd0) begin
            s       <= 1'b0;
            r       <= 1'b0;
            cnt_r   <= CHECK_LOAD;
            state_r <= CHECK;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        CHECK: begin
          if (cnt_r == 4'd0) begin
            if ((q != exp_r) || (qn != !q)) begin
              err <= 1'b1;
            end
            done    <= 1'b1;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          s       <= 1'b0;
          r       <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
